pin_entry_ctrl: RTL and testbench
=================================

# pin_entry_ctrl

Parametrised keypad PIN-entry controller. It sits between the matrix-keypad scanner and the LCD1602 controller. It buffers up to PIN_LEN digits and echoes each digit (or a mask character) to the LCD second line. It also compares the entry against a re-programmable stored code, counts failed attempts with a timed lockout, and drives the LCD message selection with a one-cycle change pulse.

## Interface
- PIN_LEN, 4: digits per code (1–8).
- DEFAULT_PIN, 16'h1234: reset value of the stored code, PIN_LEN*4 bits; the first digit is in the MS nibble.
- MAX_TRIES, 3: consecutive failures that trigger lockout (≥1).
- MASK_CHAR, 8'h2A: echo character when MASK_EN=1.
- MASK_EN, 1: 1 = echo MASK_CHAR; 0 = echo the digit's ASCII code (8'h30+digit).
- OPEN_CYCLES, 250_000_000: OPEN dwell time.
- FAIL_CYCLES, 100_000_000: FAIL dwell time.
- LOCK_CYCLES, 1_500_000_000: LOCKOUT dwell time.
- TIMEOUT_CYCLES, 500_000_000: inactivity timeout before a partial entry is cleared.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle pulse per debounced key press.
- key_code  in  4  0x0–0x9 digit, 0xA enter, 0xB backspace, 0xC clear, 0xD program; 0xE and 0xF are ignored.
- char_valid  out  1  one-cycle pulse: write char_data at char_pos.
- char_data  out  8  echo character.
- char_pos  out  3  column index, 0..PIN_LEN-1.
- clear_line  out  1  one-cycle pulse: blank the LCD second line.
- sel_msg  out  2  01 INGRESA CLAVE, 10 ABIERTO, 11 ERROR, 00 BLOQUEADO.
- message_change  out  1  one-cycle pulse when sel_msg takes a new value.
- unlock  out  1  high while in OPEN.
- locked  out  1  high while in LOCKOUT.
- tries  out  ceil(log2(MAX_TRIES+1))  current consecutive-failure count.

## Operation
- States: ENTRY, CHECK, OPEN, FAIL, LOCKOUT, PROG.
- Digit buffer: PIN_LEN nibbles plus a count (0..PIN_LEN).
- Timer: one 32-bit down-counter shared by all dwell and timeout periods.
- Keys with key_valid=0, and codes 0xE/0xF, are ignored in every state.

ENTRY:
- Digit with count<PIN_LEN: store it, count+1, pulse char_valid at the old count.
- Digit with count=PIN_LEN: ignored.
- B with count>0: count-1; char_valid at the new count with char_data=8'h20.
- B with count=0: ignored.
- C: count=0, pulse clear_line.
- A: go to CHECK. If count<PIN_LEN, CHECK fails unconditionally.
- D: ignored.
- Any accepted key reloads the timeout.
- If the timeout expires with count>0: count=0, pulse clear_line.

CHECK (one cycle):
- Match → OPEN, tries=0.
- Otherwise tries+1, then:
  - tries reaches MAX_TRIES → LOCKOUT;
  - else → FAIL.
- The buffer is cleared and clear_line pulses on CHECK exit.

OPEN:
- Exits to ENTRY after OPEN_CYCLES, or on C.
- D → PROG (count=0, sel_msg=01).
- Other keys ignored.

FAIL:
- After FAIL_CYCLES → ENTRY.
- All keys ignored.

LOCKOUT:
- After LOCK_CYCLES → ENTRY with tries=0.
- All keys ignored.

PROG:
- Digit, B and C keys behave as in ENTRY.
- A with count=PIN_LEN: load the stored code from the buffer → ENTRY.
- A with count<PIN_LEN: discard the buffer → OPEN, keeping the old code.
- Timeout behaves as in ENTRY, but expiry returns to OPEN.

Message mapping:
- ENTRY and PROG → 01; OPEN → 10; FAIL → 11; LOCKOUT → 00.
- message_change pulses only when the value actually changes. OPEN→PROG (10→01) pulses; PROG→ENTRY does not.

## Timing
- Reset values:
  - state ENTRY, count 0, tries 0, stored code DEFAULT_PIN;
  - sel_msg=01;
  - char_valid, clear_line, message_change, unlock, locked all 0;
  - char_data=8'h20, char_pos=0.
- All outputs are registered.
- Digit, backspace or clear key at edge k: the pulse appears in cycle k+1.
- Enter at edge k:
  - state is CHECK in cycle k+1;
  - OPEN/FAIL/LOCKOUT begins in cycle k+2;
  - in cycle k+2, unlock/locked, sel_msg, message_change and clear_line are all valid.
- Dwell N cycles: the state is held for exactly N cycles from entry, then transitions.
- A key pulse arriving in the same cycle as a timer expiry is dropped; the expiry wins.
- Reset asserted mid-operation returns everything to reset values on the next edge. The stored code reverts to DEFAULT_PIN.

## Test plan
- Reset, keys 1,2,3,4,A:
  - char_valid pulses at pos 0..3 with 8'h2A;
  - two cycles after A: unlock=1, sel_msg=10, message_change one cycle;
  - OPEN_CYCLES later: sel_msg=01.
- Keys 1,2,9,B,3,4,A: backspace writes 8'h20 at pos 2, entry 1234 accepted → OPEN.
- Key 5,A three times (MAX_TRIES=3):
  - FAIL twice with tries=1,2, then LOCKOUT with locked=1, sel_msg=00;
  - keys during lockout produce no outputs;
  - after LOCK_CYCLES: tries=0.
- Programming:
  - in OPEN press D,9,8,7,6,A → ENTRY;
  - 1234,A → FAIL;
  - 9876,A → OPEN.
- Keys 1,2 then idle TIMEOUT_CYCLES: clear_line pulses, count=0; 1234,A still opens. Repeat with five digits: the fifth is ignored.
- Reset asserted in PROG after 2 digits: all outputs at reset values; DEFAULT_PIN is restored.

Source files
------------

// File: rtl/pin_entry_ctrl.sv
// pin_entry_ctrl
// Keypad PIN-entry controller placed between a matrix-keypad scanner and an
// LCD1602 controller. It buffers up to PIN_LEN digits and echoes each one
// (or a mask character) on the LCD second line. It compares a completed
// entry with a re-programmable stored code and counts consecutive failures,
// locking the keypad out for a while once MAX_TRIES is reached. It also
// selects the LCD message and pulses a change strobe.
//
// Ports
//   clk            in   system clock
//   reset          in   synchronous, active-high reset
//   key_valid      in   one-cycle pulse per debounced key press
//   key_code       in   0-9 digit, A enter, B backspace, C clear, D program
//   char_valid     out  one-cycle pulse: write char_data at char_pos
//   char_data      out  echo character (mask, ASCII digit, or space)
//   char_pos       out  LCD column, 0..PIN_LEN-1
//   clear_line     out  one-cycle pulse: blank the LCD second line
//   sel_msg        out  01 enter code, 10 open, 11 error, 00 locked out
//   message_change out  one-cycle pulse when sel_msg takes a new value
//   unlock         out  high while open
//   locked         out  high while locked out
//   tries          out  consecutive-failure count
module pin_entry_ctrl #(
    parameter int                   PIN_LEN        = 4,
    parameter logic [PIN_LEN*4-1:0] DEFAULT_PIN    = 16'h1234,
    parameter int                   MAX_TRIES      = 3,
    parameter logic [7:0]           MASK_CHAR      = 8'h2A,
    parameter bit                   MASK_EN        = 1'b1,
    parameter int                   OPEN_CYCLES    = 250_000_000,
    parameter int                   FAIL_CYCLES    = 100_000_000,
    parameter int                   LOCK_CYCLES    = 1_500_000_000,
    parameter int                   TIMEOUT_CYCLES = 500_000_000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             key_valid,
    input  logic [3:0]                       key_code,
    output logic                             char_valid,
    output logic [7:0]                       char_data,
    output logic [2:0]                       char_pos,
    output logic                             clear_line,
    output logic [1:0]                       sel_msg,
    output logic                             message_change,
    output logic                             unlock,
    output logic                             locked,
    output logic [$clog2(MAX_TRIES+1)-1:0]   tries
);

    localparam int          TW        = $clog2(MAX_TRIES + 1);
    localparam logic [3:0]  PIN_LEN_C = 4'(PIN_LEN);
    localparam logic [TW-1:0] MAX_C   = TW'(MAX_TRIES);

    typedef enum logic [2:0] {
        ST_ENTRY = 3'd0,
        ST_CHECK = 3'd1,
        ST_OPEN  = 3'd2,
        ST_FAIL  = 3'd3,
        ST_LOCK  = 3'd4,
        ST_PROG  = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic [3:0]             count_q, count_d;
    logic [PIN_LEN*4-1:0]   buf_q, buf_d;
    logic [PIN_LEN*4-1:0]   code_q, code_d;
    logic [TW-1:0]          tries_q, tries_d;
    logic [31:0]            timer_q, timer_d;
    logic                   char_valid_q, char_valid_d;
    logic [7:0]             char_data_q, char_data_d;
    logic [2:0]             char_pos_q, char_pos_d;
    logic                   clear_line_q, clear_line_d;
    logic [1:0]             sel_msg_q, sel_msg_d;
    logic                   message_change_q, message_change_d;
    logic                   unlock_q, unlock_d;
    logic                   locked_q, locked_d;

    logic                   expired_s, load_s;
    logic                   is_digit_s, is_enter_s, is_back_s, is_clear_s, is_prog_s;
    logic [TW-1:0]          tries_inc_s;

    // Timer reload value for the period that starts in a given state.
    // The value is N-1 so that the state is held for exactly N cycles.
    function automatic logic [31:0] dwell(input state_e s);
        logic [31:0] v;
        case (s)
            ST_ENTRY, ST_PROG: v = 32'(TIMEOUT_CYCLES - 1);
            ST_OPEN:           v = 32'(OPEN_CYCLES - 1);
            ST_FAIL:           v = 32'(FAIL_CYCLES - 1);
            ST_LOCK:           v = 32'(LOCK_CYCLES - 1);
            default:           v = 32'd0;
        endcase
        return v;
    endfunction

    // LCD message for a state; the one-cycle CHECK state keeps the current one.
    function automatic logic [1:0] msg_of(input state_e s, input logic [1:0] cur);
        logic [1:0] m;
        case (s)
            ST_ENTRY, ST_PROG: m = 2'b01;
            ST_OPEN:           m = 2'b10;
            ST_FAIL:           m = 2'b11;
            ST_LOCK:           m = 2'b00;
            default:           m = cur;
        endcase
        return m;
    endfunction

    function automatic logic [7:0] echo(input logic [3:0] d);
        return MASK_EN ? MASK_CHAR : (8'h30 + {4'h0, d});
    endfunction

    assign expired_s  = (timer_q == 32'd0);
    assign is_digit_s = key_valid && (key_code <= 4'd9);
    assign is_enter_s = key_valid && (key_code == 4'hA);
    assign is_back_s  = key_valid && (key_code == 4'hB);
    assign is_clear_s = key_valid && (key_code == 4'hC);
    assign is_prog_s  = key_valid && (key_code == 4'hD);

    // Next-state, buffer, timer and registered-output computation.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        buf_d        = buf_q;
        code_d       = code_q;
        tries_d      = tries_q;
        char_valid_d = 1'b0;
        char_data_d  = char_data_q;
        char_pos_d   = char_pos_q;
        clear_line_d = 1'b0;
        load_s       = 1'b0;
        tries_inc_s  = tries_q + TW'(1);

        case (state_q)
            ST_ENTRY, ST_PROG: begin
                // Expiry is evaluated first so a coincident key is dropped.
                if (expired_s) begin
                    load_s = 1'b1;
                    if (count_q != 4'd0) begin
                        count_d      = 4'd0;
                        clear_line_d = 1'b1;
                    end else begin
                        count_d = count_q;
                    end
                    if (state_q == ST_PROG) begin
                        state_d = ST_OPEN;
                    end else begin
                        state_d = state_q;
                    end
                end else if (is_digit_s) begin
                    if (count_q < PIN_LEN_C) begin
                        for (int i = 0; i < PIN_LEN; i++) begin
                            buf_d[(PIN_LEN-1-i)*4 +: 4] = (count_q == 4'(i)) ? key_code
                                                          : buf_q[(PIN_LEN-1-i)*4 +: 4];
                        end
                        count_d      = count_q + 4'd1;
                        char_valid_d = 1'b1;
                        char_pos_d   = count_q[2:0];
                        char_data_d  = echo(key_code);
                        load_s       = 1'b1;
                    end else begin
                        count_d = count_q;
                    end
                end else if (is_back_s) begin
                    if (count_q != 4'd0) begin
                        count_d      = count_q - 4'd1;
                        char_valid_d = 1'b1;
                        char_pos_d   = count_d[2:0];
                        char_data_d  = 8'h20;
                        load_s       = 1'b1;
                    end else begin
                        count_d = count_q;
                    end
                end else if (is_clear_s) begin
                    count_d      = 4'd0;
                    clear_line_d = 1'b1;
                    load_s       = 1'b1;
                end else if (is_enter_s) begin
                    if (state_q == ST_ENTRY) begin
                        state_d = ST_CHECK;
                    end else if (count_q == PIN_LEN_C) begin
                        code_d  = buf_q;
                        count_d = 4'd0;
                        state_d = ST_ENTRY;
                    end else begin
                        count_d = 4'd0;
                        state_d = ST_OPEN;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_CHECK: begin
                count_d      = 4'd0;
                clear_line_d = 1'b1;
                if ((count_q == PIN_LEN_C) && (buf_q == code_q)) begin
                    state_d = ST_OPEN;
                    tries_d = '0;
                end else if (tries_inc_s == MAX_C) begin
                    state_d = ST_LOCK;
                    tries_d = tries_inc_s;
                end else begin
                    state_d = ST_FAIL;
                    tries_d = tries_inc_s;
                end
            end
            ST_OPEN: begin
                if (expired_s || is_clear_s) begin
                    state_d = ST_ENTRY;
                end else if (is_prog_s) begin
                    state_d = ST_PROG;
                    count_d = 4'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_FAIL: begin
                if (expired_s) begin
                    state_d = ST_ENTRY;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOCK: begin
                if (expired_s) begin
                    state_d = ST_ENTRY;
                    tries_d = '0;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_ENTRY;
                count_d = 4'd0;
            end
        endcase

        // Any state change or accepted key restarts the shared timer.
        timer_d = (load_s || (state_d != state_q)) ? dwell(state_d)
                : (expired_s ? 32'd0 : timer_q - 32'd1);

        sel_msg_d        = msg_of(state_d, sel_msg_q);
        message_change_d = (sel_msg_d != sel_msg_q);
        unlock_d         = (state_d == ST_OPEN);
        locked_d         = (state_d == ST_LOCK);
    end

    // State, buffer, timer and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_ENTRY;
            count_q          <= 4'd0;
            buf_q            <= '0;
            code_q           <= DEFAULT_PIN;
            tries_q          <= '0;
            timer_q          <= dwell(ST_ENTRY);
            char_valid_q     <= 1'b0;
            char_data_q      <= 8'h20;
            char_pos_q       <= 3'd0;
            clear_line_q     <= 1'b0;
            sel_msg_q        <= 2'b01;
            message_change_q <= 1'b0;
            unlock_q         <= 1'b0;
            locked_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            count_q          <= count_d;
            buf_q            <= buf_d;
            code_q           <= code_d;
            tries_q          <= tries_d;
            timer_q          <= timer_d;
            char_valid_q     <= char_valid_d;
            char_data_q      <= char_data_d;
            char_pos_q       <= char_pos_d;
            clear_line_q     <= clear_line_d;
            sel_msg_q        <= sel_msg_d;
            message_change_q <= message_change_d;
            unlock_q         <= unlock_d;
            locked_q         <= locked_d;
        end
    end

    assign char_valid     = char_valid_q;
    assign char_data      = char_data_q;
    assign char_pos       = char_pos_q;
    assign clear_line     = clear_line_q;
    assign sel_msg        = sel_msg_q;
    assign message_change = message_change_q;
    assign unlock         = unlock_q;
    assign locked         = locked_q;
    assign tries          = tries_q;

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// Self-checking bench for pin_entry_ctrl: directed scenarios with literal
// expectations followed by randomized key traffic, all compared every cycle
// against a behavioural model of the keypad controller.
module tb_pin_entry_ctrl;

    localparam int PIN_LEN = 4;
    localparam int MAXT    = 3;
    localparam int T_OPEN  = 30;
    localparam int T_FAIL  = 20;
    localparam int T_LOCK  = 50;
    localparam int T_IDLE  = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       char_valid, clear_line, message_change, unlock, locked;
    logic [7:0] char_data;
    logic [2:0] char_pos;
    logic [1:0] sel_msg;
    logic [1:0] tries;

    pin_entry_ctrl #(
        .PIN_LEN(PIN_LEN), .DEFAULT_PIN(16'h1234), .MAX_TRIES(MAXT),
        .MASK_CHAR(8'h2A), .MASK_EN(1'b1), .OPEN_CYCLES(T_OPEN),
        .FAIL_CYCLES(T_FAIL), .LOCK_CYCLES(T_LOCK), .TIMEOUT_CYCLES(T_IDLE)
    ) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .char_valid(char_valid), .char_data(char_data), .char_pos(char_pos),
        .clear_line(clear_line), .sel_msg(sel_msg), .message_change(message_change),
        .unlock(unlock), .locked(locked), .tries(tries)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: mode names, entered digits as a queue, stored code
    // as an array, and cycles elapsed in the current waiting period.
    localparam int M_ENTRY = 0, M_CHECK = 1, M_OPEN = 2, M_FAIL = 3, M_LOCK = 4, M_PROG = 5;
    int mode;
    int digs[$];
    int code_m[PIN_LEN];
    int tries_m;
    int elapsed;
    logic       e_cv, e_cl, e_mc, e_unl, e_lck;
    logic [7:0] e_cd;
    logic [2:0] e_cp;
    logic [1:0] e_sel;

    function automatic int period(input int m);
        case (m)
            M_ENTRY, M_PROG: return T_IDLE;
            M_OPEN:          return T_OPEN;
            M_FAIL:          return T_FAIL;
            M_LOCK:          return T_LOCK;
            default:         return 1;
        endcase
    endfunction

    task automatic model_step();
        int  prev, k;
        bit  restart, expire, ok;
        logic [1:0] ns;
        if (reset) begin
            mode = M_ENTRY; digs.delete(); code_m = '{1, 2, 3, 4};
            tries_m = 0; elapsed = 0;
            e_cv = 1'b0; e_cd = 8'h20; e_cp = 3'd0; e_cl = 1'b0; e_sel = 2'b01;
            e_mc = 1'b0; e_unl = 1'b0; e_lck = 1'b0;
            return;
        end
        e_cv = 1'b0; e_cl = 1'b0;
        prev = mode; restart = 1'b0;
        expire = (mode != M_CHECK) && (elapsed == period(mode) - 1);
        k = key_valid ? int'(key_code) : 15;
        case (mode)
            M_ENTRY, M_PROG: begin
                if (expire) begin
                    restart = 1'b1;
                    if (digs.size() > 0) begin digs.delete(); e_cl = 1'b1; end
                    if (mode == M_PROG) mode = M_OPEN;
                end else if (k <= 9) begin
                    if (digs.size() < PIN_LEN) begin
                        e_cv = 1'b1; e_cp = 3'(digs.size()); e_cd = 8'h2A;
                        digs.push_back(k); restart = 1'b1;
                    end
                end else if (k == 11) begin
                    if (digs.size() > 0) begin
                        void'(digs.pop_back());
                        e_cv = 1'b1; e_cp = 3'(digs.size()); e_cd = 8'h20; restart = 1'b1;
                    end
                end else if (k == 12) begin
                    digs.delete(); e_cl = 1'b1; restart = 1'b1;
                end else if (k == 10) begin
                    if (mode == M_ENTRY) mode = M_CHECK;
                    else if (digs.size() == PIN_LEN) begin
                        for (int i = 0; i < PIN_LEN; i++) code_m[i] = digs[i];
                        digs.delete(); mode = M_ENTRY;
                    end else begin
                        digs.delete(); mode = M_OPEN;
                    end
                end
            end
            M_CHECK: begin
                ok = (digs.size() == PIN_LEN);
                for (int i = 0; i < digs.size(); i++) if (digs[i] != code_m[i]) ok = 1'b0;
                digs.delete(); e_cl = 1'b1;
                if (ok) begin mode = M_OPEN; tries_m = 0; end
                else begin
                    tries_m++;
                    mode = (tries_m == MAXT) ? M_LOCK : M_FAIL;
                end
            end
            M_OPEN: begin
                if (expire || k == 12) mode = M_ENTRY;
                else if (k == 13) begin mode = M_PROG; digs.delete(); end
            end
            M_FAIL: if (expire) mode = M_ENTRY;
            M_LOCK: if (expire) begin mode = M_ENTRY; tries_m = 0; end
            default: mode = M_ENTRY;
        endcase
        if (mode != prev || restart) elapsed = 0; else elapsed++;
        case (mode)
            M_ENTRY, M_PROG: ns = 2'b01;
            M_OPEN:          ns = 2'b10;
            M_FAIL:          ns = 2'b11;
            M_LOCK:          ns = 2'b00;
            default:         ns = e_sel;
        endcase
        e_mc = (ns != e_sel); e_sel = ns;
        e_unl = (mode == M_OPEN); e_lck = (mode == M_LOCK);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("char_valid", 32'(char_valid), 32'(e_cv));
        chk("char_data", 32'(char_data), 32'(e_cd));
        chk("char_pos", 32'(char_pos), 32'(e_cp));
        chk("clear_line", 32'(clear_line), 32'(e_cl));
        chk("sel_msg", 32'(sel_msg), 32'(e_sel));
        chk("message_change", 32'(message_change), 32'(e_mc));
        chk("unlock", 32'(unlock), 32'(e_unl));
        chk("locked", 32'(locked), 32'(e_lck));
        chk("tries", 32'(tries), 32'(tries_m));
    endtask

    // One clock: inputs already set, edge, model update, compare after edge.
    task automatic step(input logic kv, input int kc);
        key_valid = kv;
        key_code  = 4'(kc);
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic press(input int kc); step(1'b1, kc); endtask
    task automatic idle(input int n); for (int i = 0; i < n; i++) step(1'b0, 0); endtask
    task automatic do_reset(); reset = 1'b1; step(1'b0, 0); reset = 1'b0; endtask
    task automatic type4(input int a, input int b, input int c, input int d);
        press(a); press(b); press(c); press(d);
    endtask

    int n;

    initial begin
        // Reset state
        reset = 1'b1; step(1'b0, 0); step(1'b0, 0); reset = 1'b0;
        chk("rst_sel", 32'(sel_msg), 32'h1);
        chk("rst_char_data", 32'(char_data), 32'h20);
        chk("rst_unlock", 32'(unlock), 32'h0);
        chk("rst_tries", 32'(tries), 32'h0);

        // Correct entry with masked echo, then full OPEN dwell
        for (int i = 0; i < 4; i++) begin
            press(i + 1);
            chk("echo_valid", 32'(char_valid), 32'h1);
            chk("echo_pos", 32'(char_pos), 32'(i));
            chk("echo_data", 32'(char_data), 32'h2A);
        end
        press(10);
        chk("check_unlock", 32'(unlock), 32'h0);
        idle(1);
        chk("open_unlock", 32'(unlock), 32'h1);
        chk("open_sel", 32'(sel_msg), 32'h2);
        chk("open_mc", 32'(message_change), 32'h1);
        chk("open_clear", 32'(clear_line), 32'h1);
        n = 1;
        for (int i = 0; i < 200 && unlock; i++) begin idle(1); if (unlock) n++; end
        chk("open_dwell", 32'(n), 32'(T_OPEN));
        chk("open_exit_sel", 32'(sel_msg), 32'h1);

        // Backspace
        press(1); press(2); press(9); press(11);
        chk("bs_valid", 32'(char_valid), 32'h1);
        chk("bs_pos", 32'(char_pos), 32'h2);
        chk("bs_data", 32'(char_data), 32'h20);
        press(3); press(4); press(10); idle(1);
        chk("bs_open", 32'(unlock), 32'h1);
        press(12); idle(1);

        // Three failures lead to lockout
        for (int t = 1; t <= 3; t++) begin
            press(5); press(10); idle(1);
            chk("fail_tries", 32'(tries), 32'(t));
            if (t < 3) begin
                chk("fail_sel", 32'(sel_msg), 32'h3);
                for (int i = 0; i < 200 && sel_msg == 2'b11; i++) idle(1);
            end else begin
                chk("lock_locked", 32'(locked), 32'h1);
                chk("lock_sel", 32'(sel_msg), 32'h0);
            end
        end
        press(1); chk("lock_key_ignored", 32'(char_valid), 32'h0);
        press(12); chk("lock_clr_ignored", 32'(clear_line), 32'h0);
        for (int i = 0; i < 200 && locked; i++) idle(1);
        chk("unlock_tries", 32'(tries), 32'h0);

        // Programming a new code
        type4(1, 2, 3, 4); press(10); idle(1);
        press(13);
        chk("prog_sel", 32'(sel_msg), 32'h1);
        chk("prog_mc", 32'(message_change), 32'h1);
        type4(9, 8, 7, 6); press(10);
        chk("prog_done_mc", 32'(message_change), 32'h0);
        type4(1, 2, 3, 4); press(10); idle(1);
        chk("old_code_fails", 32'(sel_msg), 32'h3);
        for (int i = 0; i < 200 && sel_msg == 2'b11; i++) idle(1);
        type4(9, 8, 7, 6); press(10); idle(1);
        chk("new_code_opens", 32'(unlock), 32'h1);
        press(12); idle(2);

        // Inactivity timeout clears a partial entry
        press(1); press(2);
        n = 0;
        for (int i = 0; i < T_IDLE + 1; i++) begin idle(1); if (clear_line) n++; end
        chk("timeout_clear", 32'(n), 32'h1);
        type4(9, 8, 7, 6); press(10); idle(1);
        chk("after_timeout_open", 32'(unlock), 32'h1);
        press(12); idle(1);
        type4(9, 8, 7, 6); press(5);
        chk("fifth_ignored", 32'(char_valid), 32'h0);
        press(10); idle(1);
        chk("fifth_open", 32'(unlock), 32'h1);

        // Reset in the middle of programming restores the default code
        press(13); press(1); press(2);
        do_reset();
        chk("mid_rst_sel", 32'(sel_msg), 32'h1);
        chk("mid_rst_pos", 32'(char_pos), 32'h0);
        chk("mid_rst_unlock", 32'(unlock), 32'h0);
        type4(1, 2, 3, 4); press(10); idle(1);
        chk("default_restored", 32'(unlock), 32'h1);
        press(12);

        // Randomized traffic
        for (int it = 0; it < 600; it++) begin
            int r;
            int c[PIN_LEN];
            r = int'($urandom_range(0, 19));
            if (r < 11) begin
                press(int'($urandom_range(0, 15)));
                idle(int'($urandom_range(0, 3)));
            end else if (r < 15) begin
                c = code_m;
                for (int i = 0; i < PIN_LEN; i++) press(c[i]);
                if (r < 14) press(10);
            end else if (r < 17) begin
                press(13);
            end else if (r < 19) begin
                idle(int'($urandom_range(0, 60)));
            end else if ($urandom_range(0, 9) == 0) begin
                do_reset();
            end else begin
                step(1'b0, int'($urandom_range(0, 15)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
